y86_imem_loader: RTL

- Boot-time program loader for the single-cycle Y86-64 CPU: the write-side counterpart of the CPU's instruction fetch port.
- Receives a framed byte stream over a valid/ready byte interface and writes the payload into fetch-stage instruction memory through a byte write port.
- Holds the CPU in reset while loading; releases it only after a frame passes range and checksum checks.
- Replaces hierarchical memory preloading in benches, and is the FPGA path for downloading programs.

---
 rtl/y86_imem_loader_if.sv | 19 +
 rtl/y86_imem_loader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/y86_imem_loader_if.sv
// Byte-stream handshake into the Y86 program loader.
// A byte moves on a clock edge where rx_valid_i and rx_ready_o are both high.
interface y86_imem_loader_if;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       rx_ready_o;

    modport master (
        output rx_valid_i,
        output rx_data_i,
        input  rx_ready_o
    );

    modport slave (
        input  rx_valid_i,
        input  rx_data_i,
        output rx_ready_o
    );
endinterface

// File: rtl/y86_imem_loader.sv
// Boot loader: parses framed bytes, writes instruction memory,
// and releases the CPU reset once a frame passes range and checksum.
module y86_imem_loader #(
    parameter int          ADDR_W    = 10,
    parameter int          MEM_BYTES = 1024,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    y86_imem_loader_if.slave  rx,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              cpu_rst_n_o,
    output logic              load_done_o,
    output logic [1:0]        load_err_o
);

    typedef enum logic [3:0] {
        S_HUNT, S_A0, S_A1, S_L0, S_L1,
        S_DATA, S_CK, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] MEM_END = 17'(MEM_BYTES);

    state_t      state;
    logic [15:0] start;
    logic [15:0] len;
    logic [15:0] idx;
    logic [7:0]  sum;

    logic        acc;
    logic [7:0]  d;
    logic [16:0] end_addr;

    assign acc      = rx.rx_valid_i && rx.rx_ready_o;
    assign d        = rx.rx_data_i;
    assign end_addr = {1'b0, start} + {1'b0, d, len[7:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_HUNT;
            rx.rx_ready_o <= 1'b1;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            cpu_rst_n_o   <= 1'b0;
            load_done_o   <= 1'b0;
            load_err_o    <= 2'b00;
            start         <= '0;
            len           <= '0;
            idx           <= '0;
            sum           <= '0;
        end else begin
            mem_we_o <= 1'b0;
            unique case (state)
                S_HUNT, S_DONE, S_ERR: begin
                    if (acc && d == SYNC_BYTE) begin
                        state       <= S_A0;
                        load_err_o  <= 2'b00;
                        load_done_o <= 1'b0;
                        cpu_rst_n_o <= 1'b0;
                    end
                end
                S_A0: if (acc) begin
                    start[7:0] <= d;
                    sum        <= d;
                    state      <= S_A1;
                end
                S_A1: if (acc) begin
                    start[15:8] <= d;
                    sum         <= sum + d;
                    state       <= S_L0;
                end
                S_L0: if (acc) begin
                    len[7:0] <= d;
                    sum      <= sum + d;
                    state    <= S_L1;
                end
                S_L1: if (acc) begin
                    len[15:8] <= d;
                    sum       <= sum + d;
                    idx       <= '0;
                    if (end_addr > MEM_END) begin
                        state      <= S_ERR;
                        load_err_o <= 2'b10;
                    end else if ({d, len[7:0]} == 16'd0) begin
                        state <= S_CK;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: if (acc) begin
                    mem_we_o    <= 1'b1;
                    mem_addr_o  <= start[ADDR_W-1:0] + idx[ADDR_W-1:0];
                    mem_wdata_o <= d;
                    sum         <= sum + d;
                    idx         <= idx + 16'd1;
                    if (idx == len - 16'd1)
                        state <= S_CK;
                end
                S_CK: if (acc) begin
                    sum           <= sum + d;
                    rx.rx_ready_o <= 1'b0;
                    state         <= S_CHECK;
                end
                S_CHECK: begin
                    rx.rx_ready_o <= 1'b1;
                    if (sum == 8'd0) begin
                        state       <= S_DONE;
                        load_done_o <= 1'b1;
                        cpu_rst_n_o <= 1'b1;
                    end else begin
                        state      <= S_ERR;
                        load_err_o <= 2'b01;
                    end
                end
                default: state <= S_HUNT;
            endcase
        end
    end

endmodule
